// File: rtl/scratchpad_xbar_pkg.sv
// Shared constants and address helpers for the scratchpad crossbar.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xbar_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;

  // Bank-select bits for the default geometry.
  localparam int unsigned BB = $clog2(DEF_NUM_BANKS);

  // Low address bits pick the bank, so consecutive words interleave across banks.
  function automatic int unsigned bank_of(input logic [31:0] addr, input int unsigned bb);
    return addr & ((32'd1 << bb) - 32'd1);
  endfunction

  // Remaining upper bits select the row inside the bank.
  function automatic int unsigned row_of(input logic [31:0] addr, input int unsigned bb);
    return addr >> bb;
  endfunction

endpackage

// File: rtl/scratchpad_xbar_if.sv
// LSU-side request/response bundle for the scratchpad crossbar.
// Latency: n/a (wiring only).
// Backpressure: req_ready per channel; responses cannot be stalled.
interface scratchpad_xbar_if
  import xbar_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        resp_valid;
  logic [NUM_CH*DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/scratchpad_xbar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: grant is combinational; ptr advances on the clock after a grant.
// Backpressure: non-granted requesters simply wait; no grant leaves ptr alone.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0] ptr;
  logic [CW-1:0] ptr_nxt;

  // Cyclic search from ptr; the winner's successor becomes the next start point.
  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = (idx == NUM_CH - 1) ? '0 : CW'(idx + 1);
      end
    end
  end

  // Pointer register; reset restarts arbitration at channel 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else      ptr <= ptr_nxt;
  end
endmodule

// File: rtl/scratchpad_xbar.sv
// Crossbar from NUM_CH LSU channels into NUM_BANKS single-port SRAM banks.
// Latency: writes land the cycle they are accepted; read data returns exactly 1 cycle after accept.
// Backpressure: req_ready only for the per-bank round-robin winner; responses are never stalled.
module scratchpad_xbar
  import xbar_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  scratchpad_xbar_if.slave   bus
);
  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
  localparam int BW   = (BANK_BITS > 0) ? int'(BANK_BITS) : 1;
  localparam int RW   = ADDR_W - int'(BANK_BITS);
  localparam int ROWS = 1 << RW;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [BW-1:0]     ch_bank  [NUM_CH];
  logic [RW-1:0]     ch_row   [NUM_CH];
  logic [NUM_CH-1:0] bank_req [NUM_BANKS];
  logic [NUM_CH-1:0] bank_gnt [NUM_BANKS];

  logic [NUM_BANKS-1:0] bank_acc;
  logic [NUM_BANKS-1:0] bank_we;
  logic [RW-1:0]        bank_row   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wd    [NUM_BANKS];
  logic [CW-1:0]        bank_sel   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  logic [NUM_BANKS-1:0] bank_vld_q;
  logic [CW-1:0]        bank_ch_q [NUM_BANKS];

  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH-1:0]        resp_v;
  logic [NUM_CH*DATA_W-1:0] resp_d;
  logic [NUM_CH*DATA_W-1:0] hold_q;

  // Split each channel address into bank and row, then build per-bank candidate sets.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_bank[c] = BW'(bank_of(32'(bus.req_addr[c*ADDR_W +: ADDR_W]), BANK_BITS));
      ch_row[c]  = RW'(row_of(32'(bus.req_addr[c*ADDR_W +: ADDR_W]), BANK_BITS));
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b] = '0;
      for (int c = 0; c < NUM_CH; c++)
        bank_req[b][c] = bus.req_valid[c] && (ch_bank[c] == BW'(b));
    end
  end

  // A channel hits one bank at most, so OR-ing the grants gives its ready; reset masks it.
  always_comb begin
    ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) ready = ready | bank_gnt[b];
    bus.req_ready = rst ? ready : '0;
  end

  // Steer the winning channel's fields onto each bank's single port.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]  = 1'b0;
      bank_row[b] = '0;
      bank_wd[b]  = '0;
      bank_sel[b] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (bank_gnt[b][c]) begin
          bank_we[b]  = bus.req_we[c];
          bank_row[b] = ch_row[c];
          bank_wd[b]  = bus.req_wdata[c*DATA_W +: DATA_W];
          bank_sel[b] = CW'(c);
        end
      end
      bank_acc[b] = rst && (|bank_gnt[b]);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] rd_q;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (bank_req[b]),
      .gnt (bank_gnt[b])
    );

    // Single-port SRAM: one write or one registered read per cycle, contents not reset.
    always_ff @(posedge clk) begin
      if (bank_acc[b]) begin
        if (bank_we[b]) mem[bank_row[b]] <= bank_wd[b];
        else            rd_q <= mem[bank_row[b]];
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  // Remember which channel each bank's read belongs to; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_vld_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) bank_ch_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_vld_q[b] <= bank_acc[b] && !bank_we[b];
        bank_ch_q[b]  <= bank_sel[b];
      end
    end
  end

  // Route bank read data back to its requester; idle channels show their held value.
  always_comb begin
    resp_v = '0;
    resp_d = hold_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_vld_q[b]) begin
        resp_v[bank_ch_q[b]]                  = 1'b1;
        resp_d[bank_ch_q[b]*DATA_W +: DATA_W] = bank_rdata[b];
      end
    end
  end

  // Hold register keeps the last delivered word visible between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_q <= '0;
    else      hold_q <= resp_d;
  end

  assign bus.resp_valid = resp_v;
  assign bus.resp_rdata = resp_d;
endmodule

// File: tb/tb_scratchpad_xbar.sv
// Directed bench for scratchpad_xbar in the 4-channel, 4-bank, 10-bit address geometry.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed per step.
module tb_scratchpad_xbar;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  scratchpad_xbar_if #(.NUM_CH(4), .ADDR_W(10), .DATA_W(32)) bus ();

  scratchpad_xbar #(.NUM_CH(4), .NUM_BANKS(4), .ADDR_W(10), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int c);
    return bus.resp_rdata[c*32 +: 32];
  endfunction

  task automatic drive(input int c, input logic v, input logic we,
                       input logic [9:0] a, input logic [31:0] d);
    bus.req_valid[c]        = v;
    bus.req_we[c]           = we;
    bus.req_addr[c*10 +: 10] = a;
    bus.req_wdata[c*32 +: 32] = d;
  endtask

  task automatic idle();
    for (int c = 0; c < 4; c++) drive(c, 1'b0, 1'b0, 10'h000, 32'h0);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Single write on one channel that is expected to win immediately.
  task automatic wr(input string tag, input int c, input logic [9:0] a, input logic [31:0] d);
    drive(c, 1'b1, 1'b1, a, d);
    @(negedge clk);
    check({tag, "_rdy"}, 64'(bus.req_ready[c]), 64'd1);
    next_edge();
    drive(c, 1'b0, 1'b0, 10'h000, 32'h0);
  endtask

  // Single read on one channel: accepted at once, pulse and data one cycle later.
  task automatic rd(input string tag, input int c, input logic [9:0] a, input logic [31:0] exp);
    drive(c, 1'b1, 1'b0, a, 32'h0);
    @(negedge clk);
    check({tag, "_rdy"}, 64'(bus.req_ready[c]), 64'd1);
    next_edge();
    drive(c, 1'b0, 1'b0, 10'h000, 32'h0);
    @(negedge clk);
    check({tag, "_rvld"}, 64'(bus.resp_valid), 64'(1) << c);
    check({tag, "_data"}, 64'(rd_of(c)), 64'(exp));
    next_edge();
  endtask

  logic [31:0] pre  [4];
  logic [31:0] exp2 [4];
  logic [9:0]  adr2 [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    pre[0] = 32'h11110000; pre[1] = 32'h22221111;
    pre[2] = 32'h33332222; pre[3] = 32'h44443333;

    // Reset: requests present but nothing is accepted and outputs are zero.
    rst = 1'b0;
    idle();
    drive(0, 1'b1, 1'b0, 10'h000, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    check("rst_rvld", 64'(bus.resp_valid), 64'h0);
    check("rst_rdata_or", 64'(|bus.resp_rdata), 64'h0);
    idle();
    next_edge();
    rst = 1'b1;

    // Bank 0 with ptr=0: ch2 write wins before ch3 read of the same word.
    drive(2, 1'b1, 1'b1, 10'h008, 32'h12345678);
    drive(3, 1'b1, 1'b0, 10'h008, 32'h0);
    @(negedge clk);
    check("b0_first_rdy", 64'(bus.req_ready), 64'b0100);
    next_edge();
    drive(2, 1'b0, 1'b0, 10'h000, 32'h0);
    @(negedge clk);
    check("b0_second_rdy", 64'(bus.req_ready), 64'b1000);
    check("b0_wr_no_resp", 64'(bus.resp_valid), 64'h0);
    next_edge();
    idle();
    @(negedge clk);
    check("b0_rvld", 64'(bus.resp_valid), 64'b1000);
    check("b0_rdata", 64'(rd_of(3)), 64'h12345678);
    next_edge();

    // Write then read back on ch0, then confirm the pulse ends and data holds.
    drive(0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
    @(negedge clk);
    check("wb_wr_rdy", 64'(bus.req_ready), 64'b0001);
    next_edge();
    drive(0, 1'b1, 1'b0, 10'h005, 32'h0);
    @(negedge clk);
    check("wb_rd_rdy", 64'(bus.req_ready), 64'b0001);
    check("wb_wr_no_resp", 64'(bus.resp_valid), 64'h0);
    next_edge();
    idle();
    @(negedge clk);
    check("wb_rvld", 64'(bus.resp_valid), 64'b0001);
    check("wb_rdata", 64'(rd_of(0)), 64'hDEADBEEF);
    next_edge();
    @(negedge clk);
    check("wb_pulse_end", 64'(bus.resp_valid), 64'h0);
    check("wb_hold", 64'(rd_of(0)), 64'hDEADBEEF);
    next_edge();

    // Distinct banks: four writes then four reads, all accepted in one cycle each.
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 1'b1, 10'(c), pre[c]);
    @(negedge clk);
    check("par_wr_rdy", 64'(bus.req_ready), 64'b1111);
    next_edge();
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 1'b0, 10'(c), 32'h0);
    @(negedge clk);
    check("par_rd_rdy", 64'(bus.req_ready), 64'b1111);
    next_edge();
    idle();
    @(negedge clk);
    check("par_rvld", 64'(bus.resp_valid), 64'b1111);
    for (int c = 0; c < 4; c++) check($sformatf("par_data%0d", c), 64'(rd_of(c)), 64'(pre[c]));
    next_edge();

    // Top address lives in bank 3 row 255 and is not aliased by address 3.
    wr("wrap_wr", 1, 10'h3FF, 32'hA5A5A5A5);
    rd("wrap_rd", 2, 10'h3FF, 32'hA5A5A5A5);
    wr("wrap_wr3", 0, 10'h003, 32'h0BADF00D);
    rd("wrap_rd_again", 3, 10'h3FF, 32'hA5A5A5A5);
    rd("wrap_rd3", 0, 10'h003, 32'h0BADF00D);

    // Seed bank 1 rows used below; this also leaves bank 1's pointer at ch3.
    wr("seed9", 1, 10'h009, 32'h99990009);
    wr("seedD", 2, 10'h00D, 32'hDDDD000D);

    // Reset right after a read accept: the response is dropped and ready is masked.
    drive(0, 1'b1, 1'b0, 10'h000, 32'h0);
    @(negedge clk);
    check("mid_rd_rdy", 64'(bus.req_ready), 64'b0001);
    next_edge();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 10'h000, 32'h0);
    drive(1, 1'b1, 1'b0, 10'h001, 32'h0);
    @(negedge clk);
    check("mid_rvld", 64'(bus.resp_valid), 64'h0);
    check("mid_ready", 64'(bus.req_ready), 64'h0);
    check("mid_rdata0", 64'(rd_of(0)), 64'h0);
    next_edge();
    rst = 1'b1;
    idle();

    // Four channels contend for bank 1: grants must restart at ch0 and rotate.
    adr2[0] = 10'h001; adr2[1] = 10'h005; adr2[2] = 10'h009; adr2[3] = 10'h00D;
    exp2[0] = 32'h22221111; exp2[1] = 32'hDEADBEEF;
    exp2[2] = 32'h99990009; exp2[3] = 32'hDDDD000D;
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 1'b0, adr2[c], 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) check($sformatf("rr_rdy%0d", k), 64'(bus.req_ready), 64'(1) << k);
      if (k > 0) begin
        check($sformatf("rr_rvld%0d", k - 1), 64'(bus.resp_valid), 64'(1) << (k - 1));
        check($sformatf("rr_data%0d", k - 1), 64'(rd_of(k - 1)), 64'(exp2[k - 1]));
      end
      next_edge();
      if (k < 4) drive(k, 1'b0, 1'b0, 10'h000, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
